// File: rtl/dmi_jtag_auth_dtm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmi_jtag_auth_dtm: DTM-side DMI request engine with key-gated access,    |
// | failed-attempt counting and timed lockout.           Revision: 1.0       |
// +--------------------------------------------------------------------------+
module dmi_jtag_auth_dtm #(
  parameter int ABITS       = 7,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1024,
  parameter int CNT_W       = 16,
  localparam int DRW        = ABITS + 34,
  localparam int FW         = $clog2(MAX_FAILS + 1)
) (
  input  logic             clk_i,
  input  logic             trst_ni,
  input  logic [31:0]      key_i,
  input  logic             test_logic_reset_i,
  input  logic             capture_dr_i,
  input  logic             shift_dr_i,
  input  logic             update_dr_i,
  input  logic             dmi_access_i,
  input  logic             dtmcs_select_i,
  input  logic             dmi_reset_i,
  input  logic             dmi_hardreset_i,
  input  logic             tdi_i,
  output logic             tdo_o,
  output logic [1:0]       dmi_error_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [ABITS-1:0] req_addr_o,
  output logic [31:0]      req_data_o,
  output logic [1:0]       req_op_o,
  input  logic             resp_valid_i,
  output logic             resp_ready_o,
  input  logic [31:0]      resp_data_i,
  input  logic [1:0]       resp_err_i,
  output logic             unlocked_o,
  output logic             locked_out_o,
  output logic [FW-1:0]    fail_cnt_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ       = 3'd1,
    WAIT_READ  = 3'd2,
    WRITE      = 3'd3,
    WAIT_WRITE = 3'd4,
    LOCKOUT    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [DRW-1:0]   dr_q, dr_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       error_q, error_d;
  logic             unlocked_q, unlocked_d;
  logic [FW-1:0]    fail_q, fail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hr_pend_q, hr_pend_d;

  logic [1:0]       dr_op;
  logic [31:0]      dr_data;
  logic [ABITS-1:0] dr_addr;
  logic             busy, op_failed, hr_req, hr_apply, dmi_clear, decode, in_flight;
  logic [1:0]       cap_err;

  assign dr_op   = dr_q[1:0];
  assign dr_data = dr_q[33:2];
  assign dr_addr = dr_q[DRW-1:34];

  assign in_flight = (state_q == READ) || (state_q == WAIT_READ) ||
                     (state_q == WRITE) || (state_q == WAIT_WRITE);
  assign busy      = (update_dr_i && in_flight) ||
                     (capture_dr_i && ((state_q == READ) || (state_q == WAIT_READ)));
  assign hr_req    = dmi_hardreset_i & dtmcs_select_i;
  assign dmi_clear = dmi_reset_i & dtmcs_select_i;
  // A hardreset seen mid-transaction is deferred until the handshake completes.
  assign hr_apply  = ((state_q == IDLE) && (hr_req || hr_pend_q)) ||
                     ((state_q == LOCKOUT) && hr_req);
  assign decode    = update_dr_i & dmi_access_i & (error_q == 2'd0);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    unlocked_d = unlocked_q;
    fail_d     = fail_q;
    cnt_d      = cnt_q;
    hr_pend_d  = hr_pend_q;
    op_failed  = 1'b0;

    if (hr_req && in_flight) hr_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (hr_apply) begin
          unlocked_d = 1'b0;
          fail_d     = '0;
          hr_pend_d  = 1'b0;
        end else if (decode) begin
          addr_d = dr_addr;
          data_d = dr_data;
          case (dr_op)
            2'd3: begin
              if (dr_data == key_i) begin
                unlocked_d = 1'b1;
                fail_d     = '0;
              end else begin
                unlocked_d = 1'b0;
                fail_d     = fail_q + 1'b1;
                if (fail_q == FW'(MAX_FAILS - 1)) begin
                  state_d = LOCKOUT;
                  cnt_d   = CNT_W'(LOCK_CYCLES - 1);
                end
              end
            end
            2'd1, 2'd2: begin
              if (unlocked_q) state_d = (dr_op == 2'd1) ? READ : WRITE;
              else            op_failed = 1'b1;
            end
            default: ;
          endcase
        end
      end
      READ:  if (req_ready_i) state_d = WAIT_READ;
      WRITE: if (req_ready_i) state_d = WAIT_WRITE;
      WAIT_READ: begin
        if (resp_valid_i) begin
          state_d   = IDLE;
          data_d    = resp_data_i;
          op_failed = (resp_err_i != 2'd0);
        end
      end
      WAIT_WRITE: begin
        if (resp_valid_i) begin
          state_d   = IDLE;
          op_failed = (resp_err_i != 2'd0);
        end
      end
      LOCKOUT: begin
        if (hr_apply) begin
          state_d    = IDLE;
          unlocked_d = 1'b0;
          fail_d     = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          fail_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear beats busy, busy beats op-failed; a sticky busy is never downgraded.
  always_comb begin
    error_d = error_q;
    if (dmi_clear || hr_apply)            error_d = 2'd0;
    else if (busy)                        error_d = 2'd3;
    else if (op_failed && error_q != 2'd3) error_d = 2'd2;
  end

  always_comb begin
    if ((error_q == 2'd3) || busy)                      cap_err = 2'd3;
    else if ((state_q == LOCKOUT) || (error_q == 2'd2)) cap_err = 2'd2;
    else                                                cap_err = 2'd0;
  end

  always_comb begin
    dr_d = dr_q;
    if (test_logic_reset_i) begin
      dr_d = '0;
    end else if (dmi_access_i) begin
      if (capture_dr_i)    dr_d = {addr_q, data_q, cap_err};
      else if (shift_dr_i) dr_d = {tdi_i, dr_q[DRW-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q    <= IDLE;
      dr_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      error_q    <= 2'd0;
      unlocked_q <= 1'b0;
      fail_q     <= '0;
      cnt_q      <= '0;
      hr_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dr_q       <= dr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      error_q    <= error_d;
      unlocked_q <= unlocked_d;
      fail_q     <= fail_d;
      cnt_q      <= cnt_d;
      hr_pend_q  <= hr_pend_d;
    end
  end

  always_comb begin
    case (state_q)
      READ:    req_op_o = 2'd1;
      WRITE:   req_op_o = 2'd2;
      default: req_op_o = 2'd0;
    endcase
  end

  assign tdo_o        = dr_q[0];
  assign dmi_error_o  = error_q;
  assign req_valid_o  = (state_q == READ) || (state_q == WRITE);
  assign req_addr_o   = addr_q;
  assign req_data_o   = data_q;
  assign resp_ready_o = 1'b1;
  assign unlocked_o   = unlocked_q;
  assign locked_out_o = (state_q == LOCKOUT);
  assign fail_cnt_o   = fail_q;

endmodule
`default_nettype wire
